// File: rtl/pipe_ctrl_pkg.sv
// Shared state codes, address sizing and flag bundle for the pipeline hazard/flush controller.
package pipe_ctrl_pkg;

    localparam logic [1:0] CTRL_IDLE       = 2'd0;
    localparam logic [1:0] CTRL_FLUSH      = 2'd1;
    localparam logic [1:0] CTRL_STALL_BUSY = 2'd2;

    localparam int ROM_DEPTH      = 4096;
    localparam int DEF_ROM_ADDR_W = $clog2(ROM_DEPTH);

    typedef struct packed {
        logic hold_pc;
        logic stall;
        logic flush_ifu;
        logic flush_idu;
    } ctrl_flags_t;

endpackage

// File: rtl/pipe_ctrl_hazard_detect.sv
// Purely combinational load-use compare between decode sources and the load in execute.
module hazard_detect (
    input  logic [4:0] rs1_addr,
    input  logic [4:0] rs2_addr,
    input  logic [1:0] rs_used,
    input  logic [4:0] ex_rd_addr,
    input  logic       ex_is_load,
    output logic       hazard
);

    logic [4:0] src_addr [2];
    logic [1:0] src_match;

    assign src_addr[0] = rs1_addr;
    assign src_addr[1] = rs2_addr;

    for (genvar gi = 0; gi < 2; gi++) begin : g_src
        assign src_match[gi] = rs_used[gi] & (src_addr[gi] == ex_rd_addr);
    end

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign hazard = ex_is_load & (ex_rd_addr != 5'd0) & (|src_match);

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard and flush controller: jump redirect/flush, busy stall with watchdog, load-use bubble.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int ROM_ADDR_W   = DEF_ROM_ADDR_W,
    parameter int FLUSH_CYCLES = 2,
    parameter int MAX_STALL    = 15
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  jump_en_i_exu_ctrl,
    input  logic [ROM_ADDR_W-1:0] jump_addr_i_exu_ctrl,
    input  logic                  busy_i_exu_ctrl,
    input  logic [4:0]            rs1_addr_i_idu_ctrl,
    input  logic [4:0]            rs2_addr_i_idu_ctrl,
    input  logic [1:0]            rs_used_i_idu_ctrl,
    input  logic [4:0]            ex_rd_addr_i_exu_ctrl,
    input  logic                  ex_is_load_i_exu_ctrl,
    output logic                  jump_en_o_ctrl_pc,
    output logic [ROM_ADDR_W-1:0] jump_addr_o_ctrl_pc,
    output logic                  hold_pc_o_ctrl_pc,
    output logic                  hold_flag_o_ctrl_ifu2idu,
    output logic                  stall_o_ctrl_ifu2idu,
    output logic                  hold_flag_o_ctrl_idu2exu,
    output logic                  stall_timeout_o
);

    localparam int FC_W = $clog2(FLUSH_CYCLES + 1);
    localparam int SC_W = $clog2(MAX_STALL + 1);

    logic [1:0]      state_reg, state_next;
    logic [FC_W-1:0] flush_cnt_reg, flush_cnt_next;
    logic [SC_W-1:0] stall_cnt_reg, stall_cnt_next;
    logic            timeout_reg, timeout_next;
    logic            busy_block_reg, busy_block_next;

    ctrl_flags_t           flags;
    logic                  jump_en_c;
    logic [ROM_ADDR_W-1:0] jump_addr_c;
    logic                  load_use;
    logic                  busy_eff;

    hazard_detect u_hazard (
        .rs1_addr   (rs1_addr_i_idu_ctrl),
        .rs2_addr   (rs2_addr_i_idu_ctrl),
        .rs_used    (rs_used_i_idu_ctrl),
        .ex_rd_addr (ex_rd_addr_i_exu_ctrl),
        .ex_is_load (ex_is_load_i_exu_ctrl),
        .hazard     (load_use)
    );

    // After a watchdog trip, busy is ignored until execute drops it at least once.
    assign busy_eff = busy_i_exu_ctrl & ~busy_block_reg;

    always_comb begin
        state_next      = state_reg;
        flush_cnt_next  = flush_cnt_reg;
        stall_cnt_next  = stall_cnt_reg;
        timeout_next    = timeout_reg;
        busy_block_next = busy_block_reg & busy_i_exu_ctrl;
        flags           = '0;
        jump_en_c       = 1'b0;
        jump_addr_c     = '0;

        if (jump_en_i_exu_ctrl) begin
            jump_en_c       = 1'b1;
            jump_addr_c     = jump_addr_i_exu_ctrl;
            flags.flush_ifu = 1'b1;
            flags.flush_idu = 1'b1;
            state_next      = (FLUSH_CYCLES == 1) ? CTRL_IDLE : CTRL_FLUSH;
            flush_cnt_next  = FC_W'(FLUSH_CYCLES - 1);
            stall_cnt_next  = '0;
        end else begin
            case (state_reg)
                CTRL_FLUSH: begin
                    flags.flush_ifu = 1'b1;
                    flags.flush_idu = 1'b1;
                    if (flush_cnt_reg <= FC_W'(1)) begin
                        flush_cnt_next = '0;
                        if (busy_eff) begin
                            state_next     = CTRL_STALL_BUSY;
                            stall_cnt_next = SC_W'(1);
                        end else begin
                            state_next = CTRL_IDLE;
                        end
                    end else begin
                        flush_cnt_next = flush_cnt_reg - FC_W'(1);
                    end
                end
                CTRL_STALL_BUSY: begin
                    if (!busy_i_exu_ctrl) begin
                        state_next     = CTRL_IDLE;
                        stall_cnt_next = '0;
                    end else if (stall_cnt_reg == SC_W'(MAX_STALL)) begin
                        // Watchdog trip: the stall is released in this very cycle.
                        state_next      = CTRL_IDLE;
                        stall_cnt_next  = '0;
                        timeout_next    = 1'b1;
                        busy_block_next = 1'b1;
                    end else begin
                        flags.hold_pc   = 1'b1;
                        flags.stall     = 1'b1;
                        flags.flush_idu = 1'b1;
                        stall_cnt_next  = stall_cnt_reg + SC_W'(1);
                    end
                end
                default: begin
                    if (busy_eff) begin
                        flags.hold_pc   = 1'b1;
                        flags.stall     = 1'b1;
                        flags.flush_idu = 1'b1;
                        state_next      = CTRL_STALL_BUSY;
                        stall_cnt_next  = SC_W'(1);
                    end else if (load_use) begin
                        flags.hold_pc   = 1'b1;
                        flags.stall     = 1'b1;
                        flags.flush_idu = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg      <= CTRL_IDLE;
            flush_cnt_reg  <= '0;
            stall_cnt_reg  <= '0;
            timeout_reg    <= 1'b0;
            busy_block_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            flush_cnt_reg  <= flush_cnt_next;
            stall_cnt_reg  <= stall_cnt_next;
            timeout_reg    <= timeout_next;
            busy_block_reg <= busy_block_next;
        end
    end

    assign jump_en_o_ctrl_pc        = ~rst & jump_en_c;
    assign jump_addr_o_ctrl_pc      = rst ? '0 : jump_addr_c;
    assign hold_pc_o_ctrl_pc        = ~rst & flags.hold_pc;
    assign stall_o_ctrl_ifu2idu     = ~rst & flags.stall;
    assign hold_flag_o_ctrl_ifu2idu = ~rst & flags.flush_ifu;
    assign hold_flag_o_ctrl_idu2exu = ~rst & flags.flush_idu;
    assign stall_timeout_o          = ~rst & timeout_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: per-cycle comparison against a cycles-remaining model plus literal pins.
module tb_pipe_ctrl;

    localparam int AW = 12;
    localparam int FC = 2;
    localparam int MS = 15;

    logic          clk;
    logic          rst;
    logic          jump;
    logic [AW-1:0] jaddr;
    logic          busy;
    logic [4:0]    rs1, rs2, ex_rd;
    logic [1:0]    used;
    logic          ex_load;

    logic          jump_en_o;
    logic [AW-1:0] jump_addr_o;
    logic          hold_pc_o, flush_ifu_o, stall_o, flush_idu_o, timeout_o;

    pipe_ctrl #(.ROM_ADDR_W(AW), .FLUSH_CYCLES(FC), .MAX_STALL(MS)) dut (
        .clk                      (clk),
        .rst                      (rst),
        .jump_en_i_exu_ctrl       (jump),
        .jump_addr_i_exu_ctrl     (jaddr),
        .busy_i_exu_ctrl          (busy),
        .rs1_addr_i_idu_ctrl      (rs1),
        .rs2_addr_i_idu_ctrl      (rs2),
        .rs_used_i_idu_ctrl       (used),
        .ex_rd_addr_i_exu_ctrl    (ex_rd),
        .ex_is_load_i_exu_ctrl    (ex_load),
        .jump_en_o_ctrl_pc        (jump_en_o),
        .jump_addr_o_ctrl_pc      (jump_addr_o),
        .hold_pc_o_ctrl_pc        (hold_pc_o),
        .hold_flag_o_ctrl_ifu2idu (flush_ifu_o),
        .stall_o_ctrl_ifu2idu     (stall_o),
        .hold_flag_o_ctrl_idu2exu (flush_idu_o),
        .stall_timeout_o          (timeout_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;
    int step_no     = 0;

    // Model: flush cycles still owed, length of the current busy stall, watchdog bookkeeping.
    int m_flush_left = 0;
    int m_stall_run  = 0;
    bit m_blocked    = 0;
    bit m_timeout    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        logic          e_jen, e_hold, e_ifu, e_stall, e_idu, e_to, hz, bz;
        logic [AW-1:0] e_addr;
        {e_jen, e_hold, e_ifu, e_stall, e_idu, e_to} = '0;
        e_addr = '0;
        bz = busy && !m_blocked;
        hz = ex_load && (ex_rd != 0) &&
             ((used[0] && rs1 == ex_rd) || (used[1] && rs2 == ex_rd));
        if (!rst) begin
            e_to = m_timeout;
            if (jump) begin
                e_jen = 1; e_addr = jaddr; e_ifu = 1; e_idu = 1;
            end else if (m_flush_left > 0) begin
                e_ifu = 1; e_idu = 1;
            end else if (m_stall_run > 0) begin
                if (busy && m_stall_run < MS) begin
                    e_hold = 1; e_stall = 1; e_idu = 1;
                end
            end else if (bz || hz) begin
                e_hold = 1; e_stall = 1; e_idu = 1;
            end
        end
        chk("outputs",
            64'({jump_en_o, jump_addr_o, hold_pc_o, flush_ifu_o, stall_o, flush_idu_o, timeout_o}),
            64'({e_jen, e_addr, e_hold, e_ifu, e_stall, e_idu, e_to}));
    end

    always @(posedge clk) begin
        bit bz;
        bz = busy && !m_blocked;
        if (rst) begin
            m_flush_left = 0; m_stall_run = 0; m_blocked = 0; m_timeout = 0;
        end else begin
            if (jump) begin
                m_flush_left = FC - 1;
                m_stall_run  = 0;
            end else if (m_flush_left > 0) begin
                m_flush_left--;
                if (m_flush_left == 0 && bz) m_stall_run = 1;
            end else if (m_stall_run > 0) begin
                if (!busy) m_stall_run = 0;
                else if (m_stall_run == MS) begin
                    m_timeout = 1; m_blocked = 1; m_stall_run = 0;
                end else m_stall_run++;
            end else if (bz) begin
                m_stall_run = 1;
            end
            if (!busy) m_blocked = 0;
        end
    end

    task automatic apply(input logic r, input logic j, input logic [AW-1:0] a, input logic b,
                         input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                         input logic [4:0] r2, input logic [1:0] u);
        @(posedge clk);
        #1;
        rst = r; jump = j; jaddr = a; busy = b;
        ex_load = ld; ex_rd = rd; rs1 = r1; rs2 = r2; used = u;
        @(negedge clk);
        step_no++;
        $display("vec %0d: rst=%b jump=%b addr=%h busy=%b load=%b rd=%0d rs1=%0d rs2=%0d used=%b -> jen=%b jaddr=%h hold=%b stall=%b fl_ifu=%b fl_idu=%b to=%b",
                 step_no, r, j, a, b, ld, rd, r1, r2, u, jump_en_o, jump_addr_o,
                 hold_pc_o, stall_o, flush_ifu_o, flush_idu_o, timeout_o);
    endtask

    task automatic idle();
        apply(0, 0, '0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic jmp(input logic [AW-1:0] a, input logic b);
        apply(0, 1, a, b, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    endtask

    task automatic bsy(input logic b);
        apply(0, 0, '0, b, 0, 5'd0, 5'd0, 5'd0, 2'b00);
    endtask

    initial begin
        rst = 1; jump = 1; jaddr = 12'h3FF; busy = 1;
        ex_load = 0; ex_rd = 0; rs1 = 0; rs2 = 0; used = 0;

        // Reset with jump and busy asserted: everything stays quiet.
        for (int i = 0; i < 2; i++) begin
            apply(1, 1, 12'h3FF, 1, 1, 5'd5, 5'd5, 5'd5, 2'b11);
            chk("rst_jump_en", 64'(jump_en_o), 64'd0);
            chk("rst_hold_pc", 64'(hold_pc_o), 64'd0);
        end
        idle();
        chk("post_rst_timeout", 64'(timeout_o), 64'd0);
        chk("post_rst_flush", 64'(flush_ifu_o), 64'd0);

        // Single jump: flags high for the jump cycle plus one flush cycle.
        jmp(12'h0A4, 0);
        chk("jump_addr", 64'(jump_addr_o), 64'h0A4);
        chk("jump_flags", 64'({flush_ifu_o, flush_idu_o, hold_pc_o}), 64'b110);
        idle();
        chk("flush_cycle", 64'({jump_en_o, flush_ifu_o, flush_idu_o}), 64'b011);
        chk("flush_addr_zero", 64'(jump_addr_o), 64'h000);
        idle();
        chk("flush_done", 64'(flush_ifu_o), 64'd0);

        // Back-to-back jumps restart the flush count.
        jmp(12'h010, 0);
        jmp(12'h200, 0);
        chk("b2b_addr", 64'(jump_addr_o), 64'h200);
        idle();
        chk("b2b_t2_flag", 64'(flush_idu_o), 64'd1);
        idle();
        chk("b2b_t3_flag", 64'(flush_idu_o), 64'd0);

        // Load-use on rs1, then the same with x0, then rs2 cases.
        apply(0, 0, '0, 0, 1, 5'd5, 5'd5, 5'd0, 2'b01);
        chk("lu_rs1", 64'({hold_pc_o, stall_o, flush_idu_o}), 64'b111);
        idle();
        apply(0, 0, '0, 0, 1, 5'd0, 5'd0, 5'd0, 2'b01);
        chk("lu_x0", 64'(hold_pc_o), 64'd0);
        apply(0, 0, '0, 0, 1, 5'd7, 5'd3, 5'd7, 2'b10);
        chk("lu_rs2", 64'(stall_o), 64'd1);
        apply(0, 0, '0, 0, 1, 5'd7, 5'd3, 5'd7, 2'b01);
        chk("lu_rs2_unused", 64'(stall_o), 64'd0);
        apply(0, 0, '0, 0, 0, 5'd7, 5'd7, 5'd7, 2'b11);
        chk("lu_not_load", 64'(stall_o), 64'd0);

        // Busy for four cycles, then released.
        for (int i = 0; i < 4; i++) begin
            bsy(1);
            chk("busy_hold", 64'({hold_pc_o, stall_o, flush_ifu_o}), 64'b110);
        end
        bsy(0);
        chk("busy_release", 64'(hold_pc_o), 64'd0);

        // Jump in the third busy cycle wins over the stall.
        bsy(1);
        bsy(1);
        jmp(12'h123, 1);
        chk("busy_jump_wins", 64'({jump_en_o, hold_pc_o, stall_o}), 64'b100);
        bsy(0);
        chk("busy_jump_flush", 64'({flush_ifu_o, hold_pc_o}), 64'b10);
        idle();

        // Busy arriving at the end of a flush goes straight into a stall.
        jmp(12'h055, 0);
        bsy(1);
        chk("flush_busy_flags", 64'({flush_ifu_o, hold_pc_o}), 64'b10);
        bsy(1);
        chk("flush_to_stall", 64'({flush_ifu_o, hold_pc_o}), 64'b01);
        bsy(0);
        idle();

        // Watchdog: 15 stall cycles, then release and a sticky timeout.
        for (int i = 0; i < 20; i++) begin
            bsy(1);
            chk("wd_hold", 64'(hold_pc_o), 64'(i < MS));
            if (i > MS) chk("wd_timeout", 64'(timeout_o), 64'd1);
        end
        bsy(0);
        bsy(1);
        chk("wd_rearmed", 64'(hold_pc_o), 64'd1);
        chk("wd_sticky", 64'(timeout_o), 64'd1);
        bsy(0);
        apply(1, 0, '0, 0, 0, 5'd0, 5'd0, 5'd0, 2'b00);
        idle();
        chk("wd_cleared", 64'(timeout_o), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
